// File: rtl/synchronizer_handshake_receiver.sv
// Destination side of a 4-phase request/acknowledge clock-domain crossing.
// Synchronizes the request, captures the source word, hands it to the consumer, then acknowledges.
`timescale 1ns/1ps
module synchronizer_handshake_receiver #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             source_request,
    input  logic [WIDTH-1:0] source_data,
    output logic             source_acknowledge,
    output logic [WIDTH-1:0] destination_data,
    output logic             destination_valid,
    input  logic             destination_ready
);

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        VALID       = 2'd1,
        ACKNOWLEDGE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STAGES-1:0] sync_chain;
    logic              request_synced;
    logic              capture;
    logic              valid_next;
    logic              acknowledge_next;

    // Request synchronizer: only the last flop is allowed to reach control logic.
    generate
        if (STAGES == 1) begin : g_single
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    sync_chain <= '0;
                end else begin
                    sync_chain <= source_request;
                end
            end
        end else begin : g_chain
            always_ff @(posedge clock) begin
                if (!resetn) begin
                    sync_chain <= '0;
                end else begin
                    sync_chain <= {sync_chain[STAGES-2:0], source_request};
                end
            end
        end
    endgenerate

    assign request_synced = sync_chain[STAGES-1];

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (request_synced)    state_next = VALID;
            VALID:       if (destination_ready) state_next = ACKNOWLEDGE;
            ACKNOWLEDGE: if (!request_synced)   state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so that they leave the block as flop outputs.
    always_comb begin
        capture          = (state == IDLE) && request_synced;
        valid_next       = (state_next == VALID);
        acknowledge_next = (state_next == ACKNOWLEDGE);
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            destination_valid  <= 1'b0;
            source_acknowledge <= 1'b0;
            destination_data   <= '0;
        end else begin
            destination_valid  <= valid_next;
            source_acknowledge <= acknowledge_next;
            if (capture) begin
                destination_data <= source_data;
            end
        end
    end

endmodule
